// File: rtl/pixel_scan_gen.sv
`default_nettype none
// ============================================================================
// Module   : pixel_scan_gen
// Purpose  : Raster walker emitting one complex sample c and its pixel address
//            per beat over valid/ready, using only adders and shifts.
// Revision : 1.0
// ============================================================================
module pixel_scan_gen #(
    parameter int Q      = 21,
    parameter int N      = 32,
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int STEP0  = 9830,
    parameter int ZSHIFT = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         frame_start,
    input  logic [N-1:0] real_coord_X,
    input  logic [N-1:0] real_coord_Y,
    input  logic [1:0]   zoom_level,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c_re,
    output logic [N-1:0] c_im,
    output logic [15:0]  pix_x,
    output logic [15:0]  pix_y,
    output logic         out_last,
    output logic         busy,
    output logic         frame_done,
    output logic         view_dirty
);

    localparam logic [15:0]  c_x_last = 16'(H_RES - 1);
    localparam logic [15:0]  c_y_last = 16'(V_RES - 1);
    localparam logic [N-1:0] c_step0  = N'(STEP0);

    // Elaboration-time sanity checks on the fixed-point format.
    if (Q <= 0 || Q >= N) begin : g_q_check
        $error("pixel_scan_gen: Q must lie in 1..N-1");
    end
    if (H_RES < 1 || V_RES < 1 || H_RES > 65536 || V_RES > 65536) begin : g_res_check
        $error("pixel_scan_gen: resolution must fit the 16-bit pixel address");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_SCAN = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;

    logic [N-1:0] r_origin_x;
    logic [N-1:0] r_origin_y;
    logic [1:0]   r_lvl;
    logic [N-1:0] r_step;
    logic [N-1:0] r_c_re;
    logic [N-1:0] r_c_im;
    logic [15:0]  r_pix_x;
    logic [15:0]  r_pix_y;
    logic         r_dirty;
    logic         r_armed;

    logic         w_xfer;
    logic         w_eol;
    logic         w_eof;
    logic         w_view_diff;
    logic [5:0]   w_shamt;
    logic [N-1:0] w_step_load;

    assign w_xfer      = (r_state == S_SCAN) && out_ready;
    assign w_eol       = (r_pix_x == c_x_last);
    assign w_eof       = w_eol && (r_pix_y == c_y_last);
    assign w_view_diff = (real_coord_X != r_origin_x) ||
                         (real_coord_Y != r_origin_y) ||
                         (zoom_level   != r_lvl);
    assign w_shamt     = 6'(ZSHIFT * int'(zoom_level));
    assign w_step_load = c_step0 >> w_shamt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Auto-rerender is only armed once a view has actually been latched,
    // so a stale comparison against reset values never starts a frame.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (frame_start || (r_dirty && r_armed)) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: w_state_nxt = S_SCAN;
            S_SCAN: begin
                if (w_xfer && w_eof) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_origin_x <= '0;
            r_origin_y <= '0;
            r_lvl      <= '0;
            r_step     <= '0;
            r_c_re     <= '0;
            r_c_im     <= '0;
            r_pix_x    <= '0;
            r_pix_y    <= '0;
            r_armed    <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_origin_x <= real_coord_X;
                    r_origin_y <= real_coord_Y;
                    r_lvl      <= zoom_level;
                    r_step     <= w_step_load;
                    r_c_re     <= real_coord_X;
                    r_c_im     <= real_coord_Y;
                    r_pix_x    <= '0;
                    r_pix_y    <= '0;
                    r_armed    <= 1'b1;
                end
                S_SCAN: begin
                    // The final beat leaves the payload in place; DONE follows.
                    if (w_xfer && !w_eof) begin
                        if (w_eol) begin
                            r_pix_x <= '0;
                            r_c_re  <= r_origin_x;
                            r_pix_y <= r_pix_y + 16'd1;
                            r_c_im  <= r_c_im - r_step;
                        end else begin
                            r_pix_x <= r_pix_x + 16'd1;
                            r_c_re  <= r_c_re + r_step;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dirty <= 1'b0;
        end else if (r_state == S_LOAD) begin
            r_dirty <= 1'b0;
        end else if (w_view_diff) begin
            r_dirty <= 1'b1;
        end
    end

    assign out_valid  = (r_state == S_SCAN);
    assign out_last   = out_valid && w_eof;
    assign busy       = (r_state == S_LOAD) || (r_state == S_SCAN);
    assign frame_done = (r_state == S_DONE);
    assign view_dirty = r_dirty;
    assign c_re       = r_c_re;
    assign c_im       = r_c_im;
    assign pix_x      = r_pix_x;
    assign pix_y      = r_pix_y;

endmodule
`default_nettype wire
